// File: rtl/aux_uart_word_loader.sv
// aux_uart_word_loader
//
// Receives 8N1 bytes on the auxiliary boot UART line and packs them
// little-endian into 32-bit words for program-memory loading. Each
// completed word is presented with an auto-incrementing word address
// and a one-cycle write strobe.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   aux_uart_rx    asynchronous serial input, idles high
//   addr_clear     one-cycle pulse; returns the word address to 0
//   byte_valid     one-cycle pulse per byte received with a good stop bit
//   byte_data      last good byte, held until the next good byte
//   word_valid     one-cycle write strobe for word_data / word_addr
//   word_addr      word address of word_data (valid with word_valid)
//   word_data      assembled word {b3,b2,b1,b0}, b0 received first
//   framing_error  one-cycle pulse when the stop bit is sampled low
//   busy           high whenever the receiver is not idle
//
// Handshake: word_valid / byte_valid are strobes with no back-pressure;
// the consumer must accept data in the cycle the strobe is high.
module aux_uart_word_loader #(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int ADDR_WIDTH    = 12,
    parameter int GAP_BITS      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aux_uart_rx,
    input  logic                  addr_clear,
    output logic                  byte_valid,
    output logic [7:0]            byte_data,
    output logic                  word_valid,
    output logic [ADDR_WIDTH-1:0] word_addr,
    output logic [31:0]           word_data,
    output logic                  framing_error,
    output logic                  busy
);

    localparam int DIV       = CLK_FREQUENCY / BAUD_RATE;
    localparam int CW        = $clog2(DIV);
    localparam int GAP_LIMIT = GAP_BITS * DIV;
    localparam int GW        = $clog2(GAP_LIMIT + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state;
    logic                  rx_meta;
    logic                  rx_s;
    logic [CW-1:0]         cnt;
    logic                  tick;
    logic [2:0]            bit_idx;
    logic [7:0]            shreg;
    logic [1:0]            byte_idx;
    logic [23:0]           word_buf;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [GW-1:0]         gap_cnt;

    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= aux_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            byte_idx      <= '0;
            word_buf      <= '0;
            addr_q        <= '0;
            gap_cnt       <= '0;
            byte_valid    <= 1'b0;
            byte_data     <= '0;
            word_valid    <= 1'b0;
            word_addr     <= '0;
            word_data     <= '0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            byte_valid    <= 1'b0;
            word_valid    <= 1'b0;
            framing_error <= 1'b0;

            // Free-running countdown; states reload it on their tick.
            if (!tick) begin
                cnt <= cnt - 1'b1;
            end

            case (state)
                S_IDLE: begin
                    // Long idle line: drop any partially assembled word.
                    if (gap_cnt != GAP_MAX) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end else begin
                        byte_idx <= '0;
                    end
                    if (!rx_s) begin
                        cnt     <= HALF_LOAD;
                        gap_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_s) begin
                            // Line went back high before mid-start-bit: glitch.
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            cnt     <= FULL_LOAD;
                            bit_idx <= '0;
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= FULL_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                            if (byte_idx == 2'd3) begin
                                word_valid <= 1'b1;
                                word_data  <= {shreg, word_buf};
                                word_addr  <= addr_q;
                                addr_q     <= addr_q + 1'b1;
                                byte_idx   <= '0;
                            end else begin
                                case (byte_idx)
                                    2'd0:    word_buf[7:0]   <= shreg;
                                    2'd1:    word_buf[15:8]  <= shreg;
                                    default: word_buf[23:16] <= shreg;
                                endcase
                                byte_idx <= byte_idx + 1'b1;
                            end
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            byte_idx      <= '0;
                            state         <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Wait out a held-low line before hunting for a start bit.
                    if (rx_s) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            // Placed last so it overrides a same-cycle increment; a word
            // already strobed keeps the address it was latched with.
            if (addr_clear) begin
                addr_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_aux_uart_word_loader.sv
// Testbench for aux_uart_word_loader (DIV = 16, ADDR_WIDTH = 4, GAP_BITS = 4).
module tb_aux_uart_word_loader;

  localparam int BIT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        addr_clear;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        word_valid;
  logic [3:0]  word_addr;
  logic [31:0] word_data;
  logic        framing_error;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Observed events
  logic [7:0]  obs_b[$];
  logic [31:0] obs_w[$];
  logic [3:0]  obs_a[$];
  int          obs_fe;

  // Expected queues from the reference model
  logic [7:0]  exp_b[$];
  logic [31:0] exp_w[$];
  logic [3:0]  exp_a[$];
  int          exp_fe;

  // Reference model state: bytes pending in the current word, next address
  logic [7:0]  m_bytes[$];
  int          m_addr;

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  aux_uart_word_loader #(
    .CLK_FREQUENCY(160),
    .BAUD_RATE(10),
    .ADDR_WIDTH(4),
    .GAP_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .aux_uart_rx(rx),
    .addr_clear(addr_clear),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .word_valid(word_valid),
    .word_addr(word_addr),
    .word_data(word_data),
    .framing_error(framing_error),
    .busy(busy)
  );

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (byte_valid === 1'b1) obs_b.push_back(byte_data);
      if (word_valid === 1'b1) begin
        obs_w.push_back(word_data);
        obs_a.push_back(word_addr);
      end
      if (framing_error === 1'b1) obs_fe++;
    end
  end

  // ---------------- reference model ----------------
  function automatic void model_byte(input logic [7:0] b);
    exp_b.push_back(b);
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      exp_w.push_back({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
      exp_a.push_back(4'(m_addr));
      m_addr = (m_addr + 1) % 16;
      m_bytes.delete();
    end
  endfunction

  function automatic void model_drop_partial();
    m_bytes.delete();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    addr_clear = 1'b0;
    repeat (4) @(negedge clk);
    obs_b.delete(); obs_w.delete(); obs_a.delete(); obs_fe = 0;
    exp_b.delete(); exp_w.delete(); exp_a.delete(); exp_fe = 0;
    m_bytes.delete(); m_addr = 0;
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop_level, input int stop_bits);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_level;
    repeat (BIT * stop_bits) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_bits(b, 1'b1, 1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    addr_clear = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (byte_valid !== 1'b0) begin miscompares++; $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); end
    vectors++; if (byte_data !== 8'h00) begin miscompares++; $display("FAIL reset_byte_data: got %h expected 00", byte_data); end
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
    vectors++; if (word_addr !== 4'h0) begin miscompares++; $display("FAIL reset_word_addr: got %h expected 0", word_addr); end
    vectors++; if (word_data !== 32'h0) begin miscompares++; $display("FAIL reset_word_data: got %h expected 0", word_data); end
    vectors++; if (framing_error !== 1'b0) begin miscompares++; $display("FAIL reset_framing_error: got %b expected 0", framing_error); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_byte();
    do_reset();
    send_byte(8'hA5);
    repeat (BIT) @(negedge clk);
    vectors++; if (obs_b.size() !== exp_b.size()) begin miscompares++; $display("FAIL single_byte_count: got %0d expected %0d", obs_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      vectors++; if (obs_b[i] !== exp_b[i]) begin miscompares++; $display("FAIL single_byte[%0d]: got %h expected %h", i, obs_b[i], exp_b[i]); end
    end
    vectors++; if (obs_w.size() !== 0) begin miscompares++; $display("FAIL single_no_word: got %0d words expected 0", obs_w.size()); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    vectors++; if (byte_data !== 8'hA5) begin miscompares++; $display("FAIL single_byte_data_held: got %h expected a5", byte_data); end
  endtask

  task automatic test_word_assembly();
    do_reset();
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_word($urandom);
    send_word($urandom);
    repeat (BIT) @(negedge clk);
    vectors++; if (obs_b.size() !== exp_b.size()) begin miscompares++; $display("FAIL word_byte_count: got %0d expected %0d", obs_b.size(), exp_b.size()); end
    vectors++; if (obs_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL word_count: got %0d expected %0d", obs_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      vectors++; if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL word_data[%0d]: got %h expected %h", i, obs_w[i], exp_w[i]); end
      vectors++; if (obs_a[i] !== exp_a[i]) begin miscompares++; $display("FAIL word_addr[%0d]: got %0d expected %0d", i, obs_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_framing_error();
    do_reset();
    send_byte(8'h11);
    // 0x22 with its stop bit held low for 20 bit times: no byte, partial word lost
    send_bits(8'h22, 1'b0, 20);
    exp_fe++;
    model_drop_partial();
    // send_bits raised the line on return; check the state just before that
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL framing_busy_while_low: got %b expected 1", busy); end
    repeat (6) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL framing_busy_after_rise: got %b expected 0", busy); end
    repeat (BIT) @(negedge clk);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    repeat (BIT) @(negedge clk);
    vectors++; if (obs_fe !== exp_fe) begin miscompares++; $display("FAIL framing_pulses: got %0d expected %0d", obs_fe, exp_fe); end
    vectors++; if (obs_b.size() !== exp_b.size()) begin miscompares++; $display("FAIL framing_byte_count: got %0d expected %0d", obs_b.size(), exp_b.size()); end
    vectors++; if (obs_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL framing_word_count: got %0d expected %0d", obs_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      vectors++; if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL framing_word[%0d]: got %h expected %h", i, obs_w[i], exp_w[i]); end
      vectors++; if (obs_a[i] !== exp_a[i]) begin miscompares++; $display("FAIL framing_addr[%0d]: got %0d expected %0d", i, obs_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_gap_flush();
    do_reset();
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    repeat (5 * BIT) @(negedge clk);
    model_drop_partial();
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    repeat (BIT) @(negedge clk);
    // 3-cycle low glitch must not start a byte
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    vectors++; if (obs_fe !== 0) begin miscompares++; $display("FAIL glitch_framing: got %0d expected 0", obs_fe); end
    vectors++; if (obs_b.size() !== exp_b.size()) begin miscompares++; $display("FAIL gap_byte_count: got %0d expected %0d", obs_b.size(), exp_b.size()); end
    vectors++; if (obs_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL gap_word_count: got %0d expected %0d", obs_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      vectors++; if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL gap_word[%0d]: got %h expected %h", i, obs_w[i], exp_w[i]); end
      vectors++; if (obs_a[i] !== exp_a[i]) begin miscompares++; $display("FAIL gap_addr[%0d]: got %0d expected %0d", i, obs_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    for (int k = 0; k < 17; k++) send_word($urandom);
    repeat (BIT) @(negedge clk);
    vectors++; if (obs_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL wrap_word_count: got %0d expected %0d", obs_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      vectors++; if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL wrap_word[%0d]: got %h expected %h", i, obs_w[i], exp_w[i]); end
      vectors++; if (obs_a[i] !== exp_a[i]) begin miscompares++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, obs_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_addr_clear();
    logic [31:0] w;
    int n;
    do_reset();
    for (int k = 0; k < 5; k++) send_word($urandom);
    w = $urandom;
    for (int i = 0; i < 3; i++) send_byte(w[i*8 +: 8]);
    model_byte(w[31:24]);
    m_addr = 0;
    n = 0;
    fork
      send_bits(w[31:24], 1'b1, 1);
      begin
        while (word_valid !== 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        if (word_valid === 1'b1) begin
          addr_clear = 1'b1;
          @(negedge clk);
          addr_clear = 1'b0;
        end
      end
    join
    vectors++; if (n >= 400) begin miscompares++; $display("FAIL clear_strobe_timeout: got no word_valid within %0d cycles expected one", n); end
    send_word($urandom);
    repeat (BIT) @(negedge clk);
    vectors++; if (obs_w.size() !== exp_w.size()) begin miscompares++; $display("FAIL clear_word_count: got %0d expected %0d", obs_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      vectors++; if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL clear_word[%0d]: got %h expected %h", i, obs_w[i], exp_w[i]); end
      vectors++; if (obs_a[i] !== exp_a[i]) begin miscompares++; $display("FAIL clear_addr[%0d]: got %0d expected %0d", i, obs_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    do_reset();
    b = 8'($urandom);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b[4];
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({byte_valid, byte_data, word_valid, word_addr, word_data, framing_error, busy} !== 47'h0) begin
        miscompares++;
        $display("FAIL midframe_reset_outputs[%0d]: got bv=%b bd=%h wv=%b wa=%h wd=%h fe=%b busy=%b expected all 0",
                 c, byte_valid, byte_data, word_valid, word_addr, word_data, framing_error, busy);
      end
    end
    reset = 1'b0;
    m_bytes.delete(); m_addr = 0;
    repeat (2 * BIT) @(negedge clk);
    send_byte(8'h3C);
    repeat (2 * BIT) @(negedge clk);
    vectors++; if (obs_b.size() !== exp_b.size()) begin miscompares++; $display("FAIL midframe_byte_count: got %0d expected %0d", obs_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      vectors++; if (obs_b[i] !== exp_b[i]) begin miscompares++; $display("FAIL midframe_byte[%0d]: got %h expected %h", i, obs_b[i], exp_b[i]); end
    end
    vectors++; if (obs_fe !== 0) begin miscompares++; $display("FAIL midframe_framing: got %0d expected 0", obs_fe); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1;
    rx = 1'b1;
    addr_clear = 1'b0;
    obs_fe = 0;
    exp_fe = 0;
    m_addr = 0;
    test_reset();
    test_single_byte();
    test_word_assembly();
    test_framing_error();
    test_gap_flush();
    test_addr_wrap();
    test_addr_clear();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
